// File: rtl/interleaved_reg_fifo.sv
// Multi-channel register FIFO: NUM_CH independent circular buffers drained
// round-robin through one FWFT consumer port that tags each word with its channel.
module interleaved_reg_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CH     = 4,
  parameter int AF_LEVEL   = 3,
  localparam int LB        = $clog2(FIFO_DEPTH),
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]          in_valid,
  output logic [NUM_CH-1:0]          in_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]            out_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*(LB+1)-1:0]   count,
  output logic [NUM_CH-1:0]          almost_full
);

  localparam int LAST_I    = FIFO_DEPTH - 1;
  localparam int CH_LAST_I = NUM_CH - 1;
  localparam logic [LB:0]      DEPTH_C   = FIFO_DEPTH[LB:0];
  localparam logic [LB:0]      AF_C      = AF_LEVEL[LB:0];
  localparam logic [LB-1:0]    LAST_C    = LAST_I[LB-1:0];
  localparam logic [CH_W-1:0]  CH_LAST_C = CH_LAST_I[CH_W-1:0];

  logic [LB:0]           cnt_w  [NUM_CH];
  logic [DATA_WIDTH-1:0] head_w [NUM_CH];

  logic            rd;
  logic            any_valid;
  logic [CH_W-1:0] grant;
  logic            hold_q, hold_d;
  logic [CH_W-1:0] held_ch_q, held_ch_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

  function automatic logic [LB-1:0] ptr_inc(input logic [LB-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [LB-1:0]         wptr_q, wptr_d;
      logic [LB-1:0]         rptr_q, rptr_d;
      logic [LB:0]           cnt_q, cnt_d;
      logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
      logic                  wr;
      logic                  rd_ch;

      // A full channel never accepts, even when its head is being read this cycle.
      assign in_ready[gi] = cnt_q < DEPTH_C;
      assign wr           = in_valid[gi] & in_ready[gi] & ~clear;
      assign rd_ch        = rd & (out_ch == CH_W'(gi)) & ~clear;

      always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clear) begin
          wptr_d = '0;
          rptr_d = '0;
          cnt_d  = '0;
        end else begin
          if (wr)    wptr_d = ptr_inc(wptr_q);
          if (rd_ch) rptr_d = ptr_inc(rptr_q);
          if (wr && !rd_ch)      cnt_d = cnt_q + 1'b1;
          else if (rd_ch && !wr) cnt_d = cnt_q - 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wptr_q <= '0;
          rptr_q <= '0;
          cnt_q  <= '0;
        end else begin
          wptr_q <= wptr_d;
          rptr_q <= rptr_d;
          cnt_q  <= cnt_d;
        end
      end

      always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= in_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end

      assign head_w[gi]                 = mem_q[rptr_q];
      assign cnt_w[gi]                  = cnt_q;
      assign count[gi*(LB+1) +: LB+1]   = cnt_q;
      assign almost_full[gi]            = cnt_q >= AF_C;
    end
  endgenerate

  // Round-robin scan starting at rr_ptr; a latched grant overrides the scan.
  always_comb begin
    logic found;
    any_valid = 1'b0;
    grant     = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      int idx;
      any_valid = any_valid | (cnt_w[i] != '0);
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && cnt_w[idx] != '0) begin
        grant = CH_W'(idx);
        found = 1'b1;
      end
    end
    if (hold_q) grant = held_ch_q;
  end

  assign out_valid = any_valid;
  assign out_ch    = any_valid ? grant : '0;
  assign out_data  = any_valid ? head_w[grant] : '0;
  assign rd        = out_valid & out_ready;

  always_comb begin
    hold_d    = hold_q;
    held_ch_d = held_ch_q;
    rr_ptr_d  = rr_ptr_q;
    if (clear) begin
      hold_d    = 1'b0;
      held_ch_d = '0;
      rr_ptr_d  = '0;
    end else if (rd) begin
      hold_d   = 1'b0;
      rr_ptr_d = (out_ch == CH_LAST_C) ? '0 : out_ch + 1'b1;
    end else if (out_valid) begin
      hold_d    = 1'b1;
      held_ch_d = out_ch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= 1'b0;
      held_ch_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      hold_q    <= hold_d;
      held_ch_q <= held_ch_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_interleaved_reg_fifo.sv
// Directed bench for interleaved_reg_fifo: a DEPTH=4 instance for most vectors
// and a DEPTH=3 instance for the pointer-wrap stream.
module tb_interleaved_reg_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] count;
  logic [3:0]  almost_full;

  logic        d3_clear;
  logic [31:0] d3_in_data;
  logic [3:0]  d3_in_valid;
  logic [3:0]  d3_in_ready;
  logic [7:0]  d3_out_data;
  logic [1:0]  d3_out_ch;
  logic        d3_out_valid;
  logic        d3_out_ready;
  logic [11:0] d3_count;
  logic [3:0]  d3_almost_full;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  interleaved_reg_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .NUM_CH(4), .AF_LEVEL(3)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .almost_full(almost_full)
  );

  interleaved_reg_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(3), .NUM_CH(4), .AF_LEVEL(2)) dut3 (
    .clk(clk), .rst(rst), .clear(d3_clear), .in_data(d3_in_data), .in_valid(d3_in_valid),
    .in_ready(d3_in_ready), .out_data(d3_out_data), .out_ch(d3_out_ch), .out_valid(d3_out_valid),
    .out_ready(d3_out_ready), .count(d3_count), .almost_full(d3_almost_full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int c, input logic [7:0] v);
    in_valid = 4'b0001 << c;
    in_data  = 32'(v) << (8 * c);
  endtask

  function automatic logic [2:0] cnt(input int c);
    return count[c*3 +: 3];
  endfunction

  initial begin
    logic [7:0] q[$];
    int nw;
    int cyc;

    rst = 1'b1; clear = 1'b0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    d3_clear = 1'b0; d3_in_data = '0; d3_in_valid = '0; d3_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();

    // Reset state
    check("rst in_ready", in_ready, 4'hF);
    check("rst out_valid", out_valid, 0);
    check("rst out_ch", out_ch, 0);
    check("rst out_data", out_data, 0);
    check("rst count", count, 0);
    check("rst almost_full", almost_full, 0);

    // 1: fill ch0 with out_ready low
    for (int k = 0; k < 4; k++) begin
      put(0, 8'h10 + 8'(k));
      tick();
      check("t1 count0", cnt(0), k + 1);
      check("t1 af0", almost_full[0], (k + 1 >= 3) ? 1 : 0);
    end
    check("t1 in_ready", in_ready, 4'b1110);
    check("t1 out_ch", out_ch, 0);
    put(0, 8'h99);
    tick();
    check("t1 full count0", cnt(0), 4);
    check("t1 full head", out_data, 8'h10);
    in_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t1 drain data", out_data, 8'h10 + 8'(k));
      tick();
    end
    check("t1 drained valid", out_valid, 0);
    out_ready = 1'b0;

    // 2: one word per channel, round-robin from ch0
    clear = 1'b1; tick(); clear = 1'b0;
    in_valid = 4'hF; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
    tick();
    in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      check("t2 valid", out_valid, 1);
      check("t2 ch", out_ch, k);
      check("t2 data", out_data, 8'hA0 + 8'(k));
      tick();
    end
    check("t2 empty valid", out_valid, 0);
    out_ready = 1'b0;

    // 3: held grant on ch2 survives a later ch0 write
    put(2, 8'h52);
    tick();
    check("t3 ch first", out_ch, 2);
    put(0, 8'h50);
    tick();
    in_valid = '0;
    check("t3 ch held", out_ch, 2);
    check("t3 data held", out_data, 8'h52);
    tick();
    check("t3 ch held2", out_ch, 2);
    out_ready = 1'b1;
    tick();
    check("t3 next ch", out_ch, 0);
    check("t3 next data", out_data, 8'h50);
    tick();
    out_ready = 1'b0;
    check("t3 empty", out_valid, 0);

    // 4: write to full channel during read is dropped; write+read at count 2 keeps count
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 4; k++) begin
      put(1, 8'h60 + 8'(k));
      tick();
    end
    check("t4 full count1", cnt(1), 4);
    check("t4 full in_ready", in_ready, 4'b1101);
    put(1, 8'h6F); out_ready = 1'b1;
    tick();
    in_valid = '0;
    check("t4 drop count1", cnt(1), 3);
    check("t4 head", out_data, 8'h61);
    tick();
    check("t4 count2", cnt(1), 2);
    put(1, 8'h64);
    tick();
    in_valid = '0;
    check("t4 wr+rd count", cnt(1), 2);
    check("t4 order a", out_data, 8'h63);
    tick();
    check("t4 order b", out_data, 8'h64);
    tick();
    check("t4 empty", out_valid, 0);
    out_ready = 1'b0;

    // 5: DEPTH=3 instance, ch3, 10 words through wrapping pointers
    for (int k = 0; k < 3; k++) begin
      d3_in_valid = 4'b1000; d3_in_data = {8'h70 + 8'(k), 24'h0};
      tick();
      q.push_back(8'h70 + 8'(k));
    end
    d3_in_valid = '0;
    check("t5 full count3", d3_count[9 +: 3], 3);
    check("t5 full in_ready", d3_in_ready, 4'b0111);
    check("t5 af3", d3_almost_full, 4'b1000);
    nw = 3; cyc = 0;
    d3_out_ready = 1'b1;
    while (q.size() > 0 || nw < 10) begin
      logic do_wr;
      do_wr = (nw < 10) && (q.size() < 3);
      d3_in_valid = do_wr ? 4'b1000 : 4'b0000;
      d3_in_data  = {8'h70 + 8'(nw), 24'h0};
      check("t5 valid", d3_out_valid, (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) begin
        check("t5 ch", d3_out_ch, 3);
        check("t5 data", d3_out_data, q[0]);
      end
      tick();
      if (q.size() > 0) void'(q.pop_front());
      if (do_wr) begin
        q.push_back(8'h70 + 8'(nw));
        nw++;
      end
      cyc++;
      if (cyc > 40) begin
        n_checks++; n_fail++;
        $display("FAIL t5 timeout: got %0d cycles, expected <= 40", cyc);
        break;
      end
    end
    d3_in_valid = '0;
    check("t5 drained", d3_out_valid, 0);

    // 6a: clear with in_valid high drops the push and empties all channels
    put(0, 8'h80); tick();
    put(2, 8'h82); tick();
    clear = 1'b1; in_valid = 4'hF; in_data = 32'hCCCCCCCC; out_ready = 1'b1;
    tick();
    clear = 1'b0; in_valid = '0; out_ready = 1'b0;
    check("t6 clr count", count, 0);
    check("t6 clr valid", out_valid, 0);
    check("t6 clr in_ready", in_ready, 4'hF);
    check("t6 clr out_data", out_data, 0);

    // 6b: asynchronous reset mid-stream
    put(1, 8'h91); tick();
    put(3, 8'h93); tick();
    check("t6 pre-rst count", count, 12'b001_000_001_000);
    #2;
    rst = 1'b1; in_valid = 4'hF; in_data = 32'hDDDDDDDD;
    #1;
    check("t6 async count", count, 0);
    check("t6 async valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = '0;
    tick();
    check("t6 rst count", count, 0);
    check("t6 rst in_ready", in_ready, 4'hF);
    check("t6 rst out_ch", out_ch, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
